// File: rtl/jt900h_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jt900h_pkg                                                |
// | Purpose  : Shared constants for the jt900h opcode prefetch queue:    |
// |            address width and the queue FSM state encodings.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package jt900h_pkg;

  // Width of every CPU-side address (pc, bus_addr, flush_addr)
  localparam int OPQ_AW = 24;

  // Prefetch FSM encodings
  localparam logic [1:0] OPQ_IDLE = 2'd0;  // no bus access in flight
  localparam logic [1:0] OPQ_READ = 2'd1;  // access in flight, data is kept
  localparam logic [1:0] OPQ_DROP = 2'd2;  // access in flight, data is discarded

endpackage
`default_nettype wire

// File: rtl/jt900h_opq_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jt900h_opq_buf                                            |
// | Purpose  : DEPTH-byte circular byte store for the opcode queue.      |
// |            Write port takes one BUSB-byte bus beat and drops its     |
// |            low `skip` bytes; read port returns WIN bytes starting at |
// |            rd_ptr, wrapping around the end of the store.             |
// | Ports    : clk, rst (async, active-low), cen                         |
// |            we, wr_ptr, skip, din  -- write side                      |
// |            rd_ptr, dout           -- rotated read window             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module jt900h_opq_buf #(
  parameter int BUSB  = 2,
  parameter int DEPTH = 8,
  parameter int WIN   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cen,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
  input  logic [1:0]                 skip,
  input  logic [8*BUSB-1:0]          din,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [8*WIN-1:0]           dout
);

  localparam int c_pw = $clog2(DEPTH);

  logic [7:0]      r_mem   [DEPTH];
  logic [c_pw-1:0] w_waddr [BUSB];
  logic            w_wen   [BUSB];

  // Bus byte i lands at wr_ptr + i - skip, so the first kept byte of a
  // misaligned beat is stored at wr_ptr and the stream stays contiguous.
  genvar gi;
  generate
    for (gi = 0; gi < BUSB; gi++) begin : g_wr_lane
      localparam logic [c_pw-1:0] c_off  = c_pw'(gi);
      localparam logic [1:0]      c_lane = 2'(gi);
      assign w_waddr[gi] = wr_ptr + c_off - c_pw'(skip);
      assign w_wen[gi]   = we && (c_lane >= skip);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
    end else if (cen) begin
      for (int i = 0; i < BUSB; i++) begin
        if (w_wen[i]) r_mem[w_waddr[i]] <= din[8*i +: 8];
      end
    end
  end

  // Read window: byte 0 is the oldest byte, indices wrap mod DEPTH
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_rd_lane
      localparam logic [c_pw-1:0] c_off = c_pw'(gi);
      assign dout[8*gi +: 8] = r_mem[rd_ptr + c_off];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/jt900h_opq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jt900h_opq                                                |
// | Purpose  : Opcode prefetch queue between memory bus and instruction  |
// |            controller. Fetches BUSB-byte words ahead of execution,   |
// |            presents a WIN-byte window and handles branch flushes to  |
// |            misaligned targets.                                       |
// | Ports    : clk, rst (async, active-low), cen (clock enable)          |
// |            flush, flush_addr      -- redirect                        |
// |            fetched                -- bytes consumed this cycle       |
// |            op, op_ok, op_cnt, pc  -- opcode window                   |
// |            bus_addr, bus_rd, bus_din, bus_ok -- memory bus           |
// |            underrun               -- sticky over-consume flag        |
// | Options  : JT900H_OPQ_CHECK_EN -- clamp fetched to op_cnt and flag   |
// |            underrun; without it underrun is tied low.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module jt900h_opq
  import jt900h_pkg::*;
#(
  parameter int BUSB  = 2,
  parameter int DEPTH = 8,
  parameter int WIN   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cen,
  input  logic                        flush,
  input  logic [OPQ_AW-1:0]           flush_addr,
  input  logic [2:0]                  fetched,
  output logic [8*WIN-1:0]            op,
  output logic                        op_ok,
  output logic [$clog2(DEPTH+1)-1:0]  op_cnt,
  output logic [OPQ_AW-1:0]           pc,
  output logic [OPQ_AW-1:0]           bus_addr,
  output logic                        bus_rd,
  input  logic [8*BUSB-1:0]           bus_din,
  input  logic                        bus_ok,
  output logic                        underrun
);

  localparam int                c_cw    = $clog2(DEPTH+1);
  localparam int                c_pw    = $clog2(DEPTH);
  localparam logic [OPQ_AW-1:0] c_amask = OPQ_AW'(BUSB-1);
  localparam logic [1:0]        c_smask = 2'(BUSB-1);

  logic [1:0]        r_st,       w_st_nxt;
  logic [c_pw-1:0]   r_rd_ptr,   w_rd_ptr_nxt;
  logic [c_pw-1:0]   r_wr_ptr,   w_wr_ptr_nxt;
  logic [c_cw-1:0]   r_cnt,      w_cnt_nxt;
  logic [OPQ_AW-1:0] r_pc,       w_pc_nxt;
  logic [OPQ_AW-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [1:0]        r_skip,     w_skip_nxt;

  logic              w_wr;
  logic [c_cw-1:0]   w_wr_bytes;
  logic [c_cw-1:0]   w_fetch;
  logic              w_space_ok;

  // A beat is only accepted in READ, on an enabled cycle, and never when a
  // flush arrives at the same time (flush wins over bus_ok).
  assign w_wr       = cen && !flush && (r_st == OPQ_READ) && bus_ok;
  assign w_wr_bytes = c_cw'(BUSB) - c_cw'(r_skip);

  // count + BUSB <= DEPTH, written without subtraction to avoid underflow
  assign w_space_ok = ({1'b0, r_cnt} + (c_cw+1)'(BUSB)) <= (c_cw+1)'(DEPTH);

`ifdef JT900H_OPQ_CHECK_EN
  localparam int c_xw = (c_cw > 3) ? c_cw : 3;

  logic w_over;
  logic r_underrun;

  assign w_over  = c_xw'(fetched) > c_xw'(r_cnt);
  assign w_fetch = w_over ? r_cnt : c_cw'(fetched);

  // Sticky until reset or flush; a flush cycle ignores fetched entirely
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_underrun <= 1'b0;
    end else if (cen) begin
      if (flush)       r_underrun <= 1'b0;
      else if (w_over) r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`else
  assign w_fetch  = c_cw'(fetched);
  assign underrun = 1'b0;
`endif

  always_comb begin
    w_st_nxt       = r_st;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = r_pc;
    w_bus_addr_nxt = r_bus_addr;
    w_skip_nxt     = r_skip;

    if (flush) begin
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
      w_cnt_nxt      = '0;
      w_pc_nxt       = flush_addr;
      w_bus_addr_nxt = flush_addr & ~c_amask;
      w_skip_nxt     = flush_addr[1:0] & c_smask;
      // An access still in flight must be drained and its data dropped.
      // If it completes in this very cycle there is nothing left to drain,
      // so the new aligned read can be issued straight away.
      case (r_st)
        OPQ_READ, OPQ_DROP: w_st_nxt = bus_ok ? OPQ_READ : OPQ_DROP;
        default:            w_st_nxt = OPQ_READ;
      endcase
    end else begin
      w_cnt_nxt    = r_cnt + (w_wr ? w_wr_bytes : '0) - w_fetch;
      w_rd_ptr_nxt = r_rd_ptr + c_pw'(w_fetch);
      w_pc_nxt     = r_pc + OPQ_AW'(w_fetch);
      if (w_wr) begin
        w_wr_ptr_nxt   = r_wr_ptr + c_pw'(w_wr_bytes);
        w_bus_addr_nxt = r_bus_addr + OPQ_AW'(BUSB);
        w_skip_nxt     = 2'd0;
      end
      case (r_st)
        OPQ_IDLE: if (w_space_ok) w_st_nxt = OPQ_READ;
        OPQ_READ: if (bus_ok)     w_st_nxt = OPQ_IDLE;
        OPQ_DROP: if (bus_ok)     w_st_nxt = OPQ_IDLE;
        default:                  w_st_nxt = OPQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st       <= OPQ_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_bus_addr <= '0;
      r_skip     <= '0;
    end else if (cen) begin
      r_st       <= w_st_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_skip     <= w_skip_nxt;
    end
  end

  jt900h_opq_buf #(
    .BUSB  (BUSB),
    .DEPTH (DEPTH),
    .WIN   (WIN)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .we     (w_wr),
    .wr_ptr (r_wr_ptr),
    .skip   (r_skip),
    .din    (bus_din),
    .rd_ptr (r_rd_ptr),
    .dout   (op)
  );

  assign bus_rd   = (r_st != OPQ_IDLE);
  assign bus_addr = r_bus_addr;
  assign op_cnt   = r_cnt;
  assign op_ok    = (r_cnt >= c_cw'(WIN));
  assign pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_jt900h_opq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_jt900h_opq                                             |
// | Purpose  : Directed self-checking bench for jt900h_opq with BUSB=2,  |
// |            DEPTH=8, WIN=4 and a memory returning address-as-data.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_jt900h_opq;

  localparam int BUSB  = 2;
  localparam int DEPTH = 8;
  localparam int WIN   = 4;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        cen        = 1'b1;
  logic        flush      = 1'b0;
  logic [23:0] flush_addr = 24'd0;
  logic [2:0]  fetched    = 3'd0;
  logic [31:0] op;
  logic        op_ok;
  logic [3:0]  op_cnt;
  logic [23:0] pc;
  logic [23:0] bus_addr;
  logic        bus_rd;
  logic [15:0] bus_din    = 16'd0;
  logic        bus_ok     = 1'b0;
  logic        underrun;

  int          n_chk    = 0;
  int          n_err    = 0;
  int          mem_lat  = 0;
  int          wait_cnt = 0;
  logic [23:0] req_addr = 24'd0;
  logic [7:0]  lo_byte  = 8'd0;

  always #5 clk = ~clk;

  jt900h_opq #(
    .BUSB  (BUSB),
    .DEPTH (DEPTH),
    .WIN   (WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .flush      (flush),
    .flush_addr (flush_addr),
    .fetched    (fetched),
    .op         (op),
    .op_ok      (op_ok),
    .op_cnt     (op_cnt),
    .pc         (pc),
    .bus_addr   (bus_addr),
    .bus_rd     (bus_rd),
    .bus_din    (bus_din),
    .bus_ok     (bus_ok),
    .underrun   (underrun)
  );

  // Memory: latches the address when a request starts, answers mem_lat
  // cycles later with a one-cycle bus_ok and data = low address byte (+1)
  always @(negedge clk) begin
    if (bus_ok) begin
      bus_ok   = 1'b0;
      wait_cnt = 0;
    end else if (bus_rd) begin
      if (wait_cnt == 0) req_addr = bus_addr;
      if (wait_cnt >= mem_lat) begin
        lo_byte = req_addr[7:0];
        bus_din = {lo_byte + 8'd1, lo_byte};
        bus_ok  = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_op_cnt",   32'(op_cnt),   32'd0);
    chk("rst_op_ok",    32'(op_ok),    32'd0);
    chk("rst_pc",       32'(pc),       32'd0);
    chk("rst_bus_rd",   32'(bus_rd),   32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_op",       op,            32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;

    // First fill from address 0
    for (int i = 0; i < 40 && !op_ok; i++) tick();
    chk("fill_op_ok",   32'(op_ok),    32'd1);
    chk("fill_op",      op,            32'h03020100);
    chk("fill_pc",      32'(pc),       32'd0);
    chk("fill_op_cnt",  32'(op_cnt),   32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("cnt_le_depth", 32'(op_cnt <= 4'd8), 32'd1);
    end
    chk("full_op_cnt",   32'(op_cnt),   32'd8);
    chk("full_bus_rd",   32'(bus_rd),   32'd0);
    chk("full_bus_addr", 32'(bus_addr), 32'h8);

    // Consume 1 then 3 bytes
    fetched = 3'd1;
    tick();
    fetched = 3'd0;
    chk("f1_pc",     32'(pc),     32'd1);
    chk("f1_op",     op,          32'h04030201);
    chk("f1_op_cnt", 32'(op_cnt), 32'd7);
    fetched = 3'd3;
    tick();
    fetched = 3'd0;
    chk("f3_pc",     32'(pc),     32'd4);
    chk("f3_op0",    32'(op[7:0]), 32'h04);
    chk("f3_op",     op,          32'h07060504);
    chk("f3_op_cnt", 32'(op_cnt), 32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("cnt_le_depth", 32'(op_cnt <= 4'd8), 32'd1);
    end
    chk("refill_op_cnt",   32'(op_cnt),   32'd8);
    chk("refill_op",       op,            32'h07060504);
    chk("refill_bus_addr", 32'(bus_addr), 32'hC);

    // Clock enable low: consume request is ignored
    cen     = 1'b0;
    fetched = 3'd2;
    tick();
    tick();
    chk("cen_pc",     32'(pc),     32'd4);
    chk("cen_op_cnt", 32'(op_cnt), 32'd8);
    cen     = 1'b1;
    fetched = 3'd0;

    // Flush to a misaligned target
    flush_addr = 24'h000105;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    chk("fl_bus_rd",   32'(bus_rd),   32'd1);
    chk("fl_bus_addr", 32'(bus_addr), 32'h104);
    chk("fl_pc",       32'(pc),       32'h105);
    chk("fl_op_cnt",   32'(op_cnt),   32'd0);
    chk("fl_op_ok",    32'(op_ok),    32'd0);
    tick();
    chk("fl_first_cnt",  32'(op_cnt),  32'd1);
    chk("fl_first_byte", 32'(op[7:0]), 32'h05);
    for (int i = 0; i < 12; i++) tick();
    chk("fl_fill_op",  op,          32'h08070605);
    chk("fl_fill_cnt", 32'(op_cnt), 32'd7);
    chk("fl_fill_pc",  32'(pc),     32'h105);

    // Flush while a slow read is in flight: its data must be dropped
    mem_lat = 3;
    fetched = 3'd4;
    tick();
    fetched = 3'd0;
    chk("slow_pc", 32'(pc), 32'h109);
    for (int i = 0; i < 20 && !bus_rd; i++) tick();
    chk("slow_bus_rd", 32'(bus_rd), 32'd1);
    flush_addr = 24'h000200;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    chk("drop_bus_rd",   32'(bus_rd),   32'd1);
    chk("drop_bus_addr", 32'(bus_addr), 32'h200);
    chk("drop_op_cnt",   32'(op_cnt),   32'd0);
    chk("drop_pc",       32'(pc),       32'h200);
    for (int i = 0; i < 40 && op_cnt == 4'd0; i++) tick();
    chk("drop_new_cnt",  32'(op_cnt),   32'd2);
    chk("drop_new_data", 32'(op[15:0]), 32'h0100);
    chk("drop_next_addr", 32'(bus_addr), 32'h202);

    // flush, bus_ok and fetched all in one cycle
    mem_lat = 0;
    for (int i = 0; i < 20 && !(bus_rd && op_cnt >= 4'd2); i++) tick();
    chk("coin_ready", 32'(bus_rd && op_cnt >= 4'd2), 32'd1);
    flush_addr = 24'h000300;
    flush      = 1'b1;
    fetched    = 3'd2;
    tick();
    flush      = 1'b0;
    fetched    = 3'd0;
    chk("coin_bus_ok",   32'(bus_ok),   32'd1);
    chk("coin_op_cnt",   32'(op_cnt),   32'd0);
    chk("coin_pc",       32'(pc),       32'h300);
    chk("coin_bus_rd",   32'(bus_rd),   32'd1);
    chk("coin_bus_addr", 32'(bus_addr), 32'h300);
    for (int i = 0; i < 40 && op_cnt < 4'd4; i++) tick();
    chk("coin_fill_op", op,       32'h03020100);
    chk("coin_fill_pc", 32'(pc),  32'h300);

    // Over-consume: op_cnt=1, fetched=3
    flush_addr = 24'h000401;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    for (int i = 0; i < 40 && op_cnt != 4'd1; i++) tick();
    chk("ur_cnt1", 32'(op_cnt), 32'd1);
    fetched = 3'd3;
    tick();
    fetched = 3'd0;
`ifdef JT900H_OPQ_CHECK_EN
    chk("ur_op_cnt",  32'(op_cnt),   32'd0);
    chk("ur_pc",      32'(pc),       32'h402);
    chk("ur_set",     32'(underrun), 32'd1);
    tick();
    tick();
    tick();
    chk("ur_sticky",  32'(underrun), 32'd1);
`else
    chk("ur_off",     32'(underrun), 32'd0);
    tick();
    tick();
    tick();
    chk("ur_off_hold", 32'(underrun), 32'd0);
`endif
    flush_addr = 24'h000000;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    chk("ur_clear",   32'(underrun), 32'd0);
    chk("end_pc",     32'(pc),       32'd0);
    chk("end_op_cnt", 32'(op_cnt),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
